// File: rtl/vedic_dot_acc.sv
// vedic_dot_acc: sums a valid/ready burst of 8-bit Vedic products into a dot-product held until taken.
// Define VEDIC_DOT_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module vedic_dot_acc #(
   parameter int ACC_W = 16,
   parameter int MAX_LEN = 16,
   localparam int CNT_W = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       prod_i,
   input  logic             prod_valid,
   input  logic             prod_last,
   output logic             prod_ready,
   output logic [ACC_W-1:0] sum_o,
   output logic [CNT_W-1:0] len_o,
   output logic             ovf_o,
   output logic             sum_valid,
   input  logic             sum_ready
);
   localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2;
   logic [1:0] state;
   logic [ACC_W-1:0] acc, acc_nxt, nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic ovf, c, accept, done;
   assign prod_ready = state != HOLD;
   assign sum_valid = state == HOLD;
   assign accept = prod_valid & prod_ready;
   assign sum_o = acc;
   assign len_o = cnt;
   assign ovf_o = ovf;
   always_comb begin
      {c, nxt} = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod_i};
      cnt_nxt = cnt + CNT_W'(1);
      done = prod_last | (cnt_nxt == CNT_W'(MAX_LEN));
`ifdef VEDIC_DOT_ACC_SAT_EN
      acc_nxt = (c | ovf) ? '1 : nxt;
`else
      acc_nxt = nxt;
`endif
   end
   // a take in HOLD only clears; the next product is accepted a cycle later
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (state == HOLD) begin
         if (sum_ready) begin
            state <= IDLE;
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
         end
      end else if (accept) begin
         state <= done ? HOLD : ACC;
         acc <= acc_nxt;
         cnt <= cnt_nxt;
         ovf <= ovf | c;
      end
   end
endmodule

// File: tb/tb_vedic_dot_acc.sv
// tb_vedic_dot_acc: directed and randomised checks of vedic_dot_acc at ACC_W=16 and ACC_W=10.
module tb_vedic_dot_acc;
   logic clk = 1'b0;
   logic rst_n, vld, sel, prod_last, sum_ready;
   logic [7:0] prod_i;
   logic pv16, pr16, ov16, sv16, pv10, pr10, ov10, sv10;
   logic [15:0] sum16;
   logic [9:0] sum10;
   logic [4:0] len16, len10;
   logic rdy, ovf, sv;
   logic [15:0] sum;
   logic [4:0] len;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   assign pv16 = vld & !sel;
   assign pv10 = vld & sel;
   assign rdy = sel ? pr10 : pr16;
   assign sv = sel ? sv10 : sv16;
   assign ovf = sel ? ov10 : ov16;
   assign sum = sel ? 16'(sum10) : sum16;
   assign len = sel ? len10 : len16;

   vedic_dot_acc #(.ACC_W(16), .MAX_LEN(16)) dut (
      .clk(clk), .rst_n(rst_n), .prod_i(prod_i), .prod_valid(pv16), .prod_last(prod_last),
      .prod_ready(pr16), .sum_o(sum16), .len_o(len16), .ovf_o(ov16), .sum_valid(sv16),
      .sum_ready(sum_ready));

   vedic_dot_acc #(.ACC_W(10), .MAX_LEN(16)) dut10 (
      .clk(clk), .rst_n(rst_n), .prod_i(prod_i), .prod_valid(pv10), .prod_last(prod_last),
      .prod_ready(pr10), .sum_o(sum10), .len_o(len10), .ovf_o(ov10), .sum_valid(sv10),
      .sum_ready(sum_ready));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic send(input logic [7:0] p, input logic l);
      int t = 0;
      prod_i = p;
      prod_last = l;
      vld = 1'b1;
      while (!rdy && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!rdy) check("send_timeout", rdy, 1);
      @(negedge clk);
      vld = 1'b0;
   endtask

   task automatic result(input string tag, input logic [15:0] s, input logic [4:0] n, input logic o);
      check({tag, "_valid"}, sv, 1);
      check({tag, "_sum"}, sum, s);
      check({tag, "_len"}, len, n);
      check({tag, "_ovf"}, ovf, o);
   endtask

   initial begin
      rst_n = 1'b0;
      vld = 1'b0;
      sel = 1'b0;
      prod_i = '0;
      prod_last = 1'b0;
      sum_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_valid", sv, 0);
      check("rst_ready", rdy, 1);
      check("rst_sum", sum, 0);
      check("rst_len", len, 0);
      check("rst_ovf", ovf, 0);

      // T1: 195+210+225, single-cycle result
      send(8'd195, 1'b0);
      send(8'd210, 1'b0);
      check("t1_mid_valid", sv, 0);
      send(8'd225, 1'b1);
      result("t1", 16'd630, 5'd3, 1'b0);
      check("t1_ready_hold", rdy, 0);
      @(negedge clk);
      check("t1_valid_drop", sv, 0);
      check("t1_ready_back", rdy, 1);

      // T2: MAX_LEN cut then a short burst
      for (int i = 0; i < 16; i++) send(8'd1, 1'b0);
      result("t2a", 16'd16, 5'd16, 1'b0);
      for (int i = 0; i < 4; i++) send(8'd1, i == 3);
      result("t2b", 16'd4, 5'd4, 1'b0);
      @(negedge clk);

      // T3: ACC_W=10 overflow
      sel = 1'b1;
      for (int i = 0; i < 5; i++) send(8'd225, i == 4);
`ifdef VEDIC_DOT_ACC_SAT_EN
      result("t3", 16'd1023, 5'd5, 1'b1);
`else
      result("t3", 16'd101, 5'd5, 1'b1);
`endif
      @(negedge clk);
      check("t3_cleared_ovf", ovf, 0);
      sel = 1'b0;

      // T4: backpressure holds result and blocks products
      sum_ready = 1'b0;
      send(8'd195, 1'b0);
      send(8'd210, 1'b0);
      send(8'd225, 1'b1);
      prod_i = 8'd99;
      prod_last = 1'b0;
      vld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_hold_sum", sum, 630);
         check("t4_hold_ready", rdy, 0);
         check("t4_hold_len", len, 3);
      end
      sum_ready = 1'b1;
      send(8'd99, 1'b1);
      result("t4_next", 16'd99, 5'd1, 1'b0);
      @(negedge clk);

      // T5: reset mid-burst and in HOLD
      send(8'd100, 1'b0);
      send(8'd50, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t5_rst_sum", sum, 0);
      check("t5_rst_len", len, 0);
      send(8'd7, 1'b1);
      result("t5", 16'd7, 5'd1, 1'b0);
      @(negedge clk);
      sum_ready = 1'b0;
      send(8'd7, 1'b1);
      check("t5_hold_valid", sv, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t5_hold_rst_valid", sv, 0);
      check("t5_hold_rst_ready", rdy, 1);

      // T6: random bursts of a*b with gaps
      for (int b = 0; b < 1000; b++) begin
         int n, exp_sum;
         n = $urandom_range(1, 16);
         exp_sum = 0;
         for (int i = 0; i < n; i++) begin
            logic [3:0] x, y;
            logic [7:0] p;
            x = 4'($urandom);
            y = 4'($urandom);
            p = x * y;
            exp_sum += int'(p);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(p, i == n - 1);
         end
         result("t6", 16'(exp_sum), 5'(n), 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         sum_ready = 1'b1;
         @(negedge clk);
         sum_ready = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
